// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Front end of the lock controller. Walks a single low column across a 4x4
// active-low matrix keypad, synchronizes the row lines, debounces both the
// press and the release of a single key, and hands the controller one
// rdy/keypress pair per qualified press.
//
// Parameters:
//   SCAN_DIV      cycles each column is driven before its rows are sampled (>=3)
//   DEBOUNCE_CNT  consecutive identical samples needed to accept a press or a
//                 release (>=1)
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   rows      keypad rows, active-low with pull-ups, asynchronous to clk
//   cols      column drive, active-low one-hot (exactly one bit low)
//   keypress  code of the last accepted key, held until the next accept
//   rdy       one-cycle strobe, keypress is valid in the same cycle
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] keypress,
    output logic       rdy
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HOLD     = 2'd2
    } state_t;

    // Key legend: row-major, columns left to right.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = 4'd10;
            4'd4:    code = 4'd4;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd6;
            4'd7:    code = 4'd11;
            4'd8:    code = 4'd7;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd9;
            4'd11:   code = 4'd12;
            4'd12:   code = 4'd14;
            4'd13:   code = 4'd0;
            4'd14:   code = 4'd15;
            default: code = 4'd13;
        endcase
        return code;
    endfunction

    logic [3:0]    rows_meta;
    logic [3:0]    rs;
    logic [DW-1:0] dwell_cnt;
    logic          sample;

    state_t        state;
    state_t        state_next;
    logic [1:0]    ci;
    logic [1:0]    ci_next;
    logic [1:0]    cr;
    logic [1:0]    cr_next;
    logic [CW-1:0] match_cnt;
    logic [CW-1:0] match_next;
    logic [CW-1:0] rel_cnt;
    logic [CW-1:0] rel_next;
    logic          accept;

    logic          row_valid;
    logic [1:0]    row_idx;
    logic          rows_idle;

    logic [3:0]    keypress_next;
    logic          rdy_next;

    // Two-flop synchronizer on the asynchronous row lines. Idle (all high)
    // out of reset so the first samples never look like a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            rows_meta <= 4'b1111;
            rs        <= 4'b1111;
        end else begin
            rows_meta <= rows;
            rs        <= rows_meta;
        end
    end

    // Free-running dwell counter. The last count of each dwell is the sample
    // point, which leaves the synchronizer time to settle after a column change.
    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_cnt <= '0;
        end else if (sample) begin
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
        end
    end

    assign sample = (dwell_cnt == DWELL_LAST);

    // A sample only counts when exactly one row is low; no row or a chord of
    // several rows is treated the same as "nothing usable".
    always_comb begin
        row_valid = 1'b0;
        row_idx   = 2'd0;
        case (rs)
            4'b1110: begin row_valid = 1'b1; row_idx = 2'd0; end
            4'b1101: begin row_valid = 1'b1; row_idx = 2'd1; end
            4'b1011: begin row_valid = 1'b1; row_idx = 2'd2; end
            4'b0111: begin row_valid = 1'b1; row_idx = 2'd3; end
            default: begin row_valid = 1'b0; row_idx = 2'd0; end
        endcase
    end

    assign rows_idle = (rs == 4'b1111);

    assign cols = ~(4'b0001 << ci);

    // State and datapath registers. Reset wins over a coincident accept, so
    // a press interrupted by reset never produces a strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            ci        <= 2'd0;
            cr        <= 2'd0;
            match_cnt <= '0;
            rel_cnt   <= '0;
            keypress  <= 4'h0;
            rdy       <= 1'b0;
        end else begin
            state     <= state_next;
            ci        <= ci_next;
            cr        <= cr_next;
            match_cnt <= match_next;
            rel_cnt   <= rel_next;
            keypress  <= keypress_next;
            rdy       <= rdy_next;
        end
    end

    // Next-state logic. Everything moves only on sample events. The column
    // stays frozen while debouncing a press and while waiting for release, so
    // the same key is watched throughout; after a release the scan restarts
    // from column 0.
    always_comb begin
        state_next = state;
        ci_next    = ci;
        cr_next    = cr;
        match_next = match_cnt;
        rel_next   = rel_cnt;
        accept     = 1'b0;

        if (sample) begin
            case (state)
                SCAN: begin
                    if (row_valid) begin
                        cr_next = row_idx;
                        if (DEBOUNCE_CNT == 1) begin
                            accept     = 1'b1;
                            match_next = '0;
                        end else begin
                            match_next = CNT_ONE;
                            state_next = PRESS_DB;
                        end
                    end else begin
                        ci_next = ci + 2'd1;
                    end
                end

                PRESS_DB: begin
                    if (row_valid && (row_idx == cr)) begin
                        if (match_cnt == CNT_LAST) begin
                            accept     = 1'b1;
                            match_next = '0;
                        end else begin
                            match_next = match_cnt + CNT_ONE;
                        end
                    end else begin
                        match_next = '0;
                        ci_next    = ci + 2'd1;
                        state_next = SCAN;
                    end
                end

                HOLD: begin
                    if (rows_idle) begin
                        if (rel_cnt == CNT_LAST) begin
                            rel_next   = '0;
                            ci_next    = 2'd0;
                            state_next = SCAN;
                        end else begin
                            rel_next = rel_cnt + CNT_ONE;
                        end
                    end else begin
                        rel_next = '0;
                    end
                end

                default: begin
                    state_next = SCAN;
                    ci_next    = 2'd0;
                    match_next = '0;
                    rel_next   = '0;
                end
            endcase

            if (accept) begin
                state_next = HOLD;
                rel_next   = '0;
            end
        end
    end

    // Output logic. cr_next is used for the row so an immediate accept from
    // SCAN (single-sample debounce) picks up the row seen in that sample.
    always_comb begin
        rdy_next      = accept;
        keypress_next = keypress;
        if (accept) begin
            keypress_next = key_code(cr_next, ci);
        end
    end

endmodule
